// File: rtl/nor_chain_pipe.sv
// nor_chain_pipe: STAGES-deep pipeline of cascaded OR/NOR gate stages with a
// valid/ready handshake, synchronous flush and a completed-output counter.
//
// Stage k computes r[k] = G(r[k-1] | side[k]) (stage 0 uses a instead of
// r[-1]), where G inverts when the transaction's inv_en was 1. Each stage
// register carries the results produced so far plus the captured side
// operands and gate mode, so the last stage holds every tap.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   flush             - clears all stage valid bits at the next edge
//   in_valid/in_ready - input handshake (in_ready is combinational)
//   a, side, inv_en   - operands and gate mode, captured on acceptance
//   out_valid/out_ready - output handshake from the last stage register
//   y                 - last stage result (top slice of taps)
//   taps              - all stage results, slice k = stage k
//   count             - completed output transactions, wraps at 16 bits
module nor_chain_pipe #(
    parameter int unsigned STAGES = 3,
    parameter int unsigned WIDTH  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          a,
    input  logic [STAGES*WIDTH-1:0]   side,
    input  logic                      inv_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          y,
    output logic [STAGES*WIDTH-1:0]   taps,
    output logic [15:0]               count
);

    localparam int unsigned TW = STAGES * WIDTH;

    // Stage registers
    logic [STAGES-1:0] v_q;
    logic [TW-1:0]     res_q  [STAGES];
    logic [TW-1:0]     side_q [STAGES];
    logic [STAGES-1:0] inv_q;
    logic [15:0]       count_q;

    // Next-state values offered to each stage by its upstream neighbour
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] up_valid;
    logic [TW-1:0]     res_d  [STAGES];
    logic [TW-1:0]     side_d [STAGES];
    logic [STAGES-1:0] inv_d;

    // Ready ripples back from out_ready; an empty stage is always ready, which
    // collapses bubbles even while the output is stalled.
    always_comb begin
        logic r;
        r   = out_ready;
        rdy = '0;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            r      = ~v_q[k] | r;
            rdy[k] = r;
        end
    end

    always_comb begin
        logic [WIDTH-1:0] g;
        up_valid = '0;
        inv_d    = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            res_d[k]  = '0;
            side_d[k] = '0;
        end

        // Stage 0 evaluates straight from the input operands.
        g = a | side[0 +: WIDTH];
        if (inv_en) g = ~g;
        up_valid[0]          = in_valid;
        res_d[0][0 +: WIDTH] = g;
        side_d[0]            = side;
        inv_d[0]             = inv_en;

        // Later stages use only the values captured with the transaction.
        for (int k = 1; k < int'(STAGES); k++) begin
            g = res_q[k-1][(k-1)*WIDTH +: WIDTH] | side_q[k-1][k*WIDTH +: WIDTH];
            if (inv_q[k-1]) g = ~g;
            up_valid[k]              = v_q[k-1];
            res_d[k]                 = res_q[k-1];
            res_d[k][k*WIDTH +: WIDTH] = g;
            side_d[k]                = side_q[k-1];
            inv_d[k]                 = inv_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q     <= '0;
            inv_q   <= '0;
            count_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                res_q[k]  <= '0;
                side_q[k] <= '0;
            end
        end else begin
            // The output handshake still completes during a flush cycle.
            if (out_valid && out_ready) count_q <= count_q + 16'd1;
            for (int k = 0; k < int'(STAGES); k++) begin
                if (flush) begin
                    v_q[k] <= 1'b0;
                end else if (rdy[k]) begin
                    v_q[k] <= up_valid[k];
                end
                // Data only moves with a real transaction; stalled stages hold.
                if (rdy[k] && up_valid[k] && !flush) begin
                    res_q[k]  <= res_d[k];
                    side_q[k] <= side_d[k];
                    inv_q[k]  <= inv_d[k];
                end
            end
        end
    end

    // Side slices already consumed and the last stage's mode copy are dead;
    // fold them here so they read as intentionally unused.
    logic unused_state;
    always_comb begin
        unused_state = ^inv_q;
        for (int k = 0; k < int'(STAGES); k++) begin
            unused_state = unused_state ^ (^side_q[k]);
        end
    end

    // Flush wins over acceptance.
    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v_q[STAGES-1];
    assign taps      = res_q[STAGES-1];
    assign y         = res_q[STAGES-1][(STAGES-1)*WIDTH +: WIDTH];
    assign count     = count_q;

endmodule

// File: tb/tb_nor_chain_pipe.sv
// Directed bench for nor_chain_pipe (STAGES=3, WIDTH=1). Expected tap values
// are hand-computed per vector; a queue holds them in acceptance order and is
// checked on every output handshake.
module tb_nor_chain_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [0:0]  a = 1'b0;
    logic [2:0]  side = 3'b000;
    logic        inv_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [0:0]  y;
    logic [2:0]  taps;
    logic [15:0] count;

    int          n_checks = 0;
    int          n_fail = 0;
    int          idx;
    bit          last_acc;
    logic [2:0]  pend_exp;
    logic [2:0]  sb[$];
    // {a, side[2:0], inv_en, expected taps[2:0]}
    logic [7:0]  vec [12];

    nor_chain_pipe #(
        .STAGES(3),
        .WIDTH (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .side     (side),
        .inv_en   (inv_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .taps     (taps),
        .count    (count)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input int i);
        in_valid = 1'b1;
        a        = vec[i][7];
        side     = vec[i][6:4];
        inv_en   = vec[i][3];
        pend_exp = vec[i][2:0];
    endtask

    // One clock: sample handshakes at the falling edge, return 1 after the rise.
    task automatic cyc();
        logic [31:0] exp;
        @(negedge clk);
        last_acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (sb.size() > 0) exp = 32'(sb.pop_front());
            else               exp = 32'hFFFF_FFFF;
            chk("out_taps", 32'(taps), exp);
            chk("out_y", 32'(y), 32'(exp[2]));
        end
        if (last_acc) sb.push_back(pend_exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec = '{8'b0_000_1_101, 8'b1_000_1_010, 8'b1_000_0_111, 8'b0_100_1_001,
                8'b0_010_0_110, 8'b0_001_1_010, 8'b0_000_0_000, 8'b0_100_0_100,
                8'b1_111_1_000, 8'b0_010_1_101, 8'b0_001_0_111, 8'b0_101_1_010};

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_taps", 32'(taps), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // NOR chain, a=0 side=000: latency 3, taps 101
        out_ready = 1'b1;
        offer(0);
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("lat_early_valid", 32'(out_valid), 32'd0);
        cyc();
        chk("lat3_valid", 32'(out_valid), 32'd1);
        chk("lat3_taps", 32'(taps), 32'b101);
        chk("lat3_y", 32'(y), 32'd1);
        chk("lat3_count_before", 32'(count), 32'd0);
        cyc();
        chk("lat3_count", 32'(count), 32'd1);
        chk("lat3_drained", 32'(out_valid), 32'd0);

        // a=1 NOR, then OR mode
        offer(1);
        cyc();
        offer(2);
        cyc();
        in_valid = 1'b0;
        cyc();
        chk("nor_a1_taps", 32'(taps), 32'b010);
        chk("nor_a1_y", 32'(y), 32'd0);
        cyc();
        chk("or_a1_taps", 32'(taps), 32'b111);
        chk("or_a1_y", 32'(y), 32'd1);
        cyc();
        chk("mode_count", 32'(count), 32'd3);

        // Eight back-to-back transactions
        for (int i = 0; i < 8; i++) begin
            offer(4 + i);
            #1;
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            cyc();
            if (i >= 2) chk("stream_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        repeat (2) begin
            cyc();
            chk("stream_valid", 32'(out_valid), 32'd1);
        end
        cyc();
        chk("stream_drained", 32'(out_valid), 32'd0);
        chk("stream_count", 32'(count), 32'd11);

        // Backpressure: only 3 fit with the output stalled
        out_ready = 1'b0;
        idx = 0;
        repeat (6) begin
            offer(idx);
            cyc();
            if (last_acc) idx++;
        end
        chk("stall_accepted", 32'(idx), 32'd3);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_taps", 32'(taps), 32'b101);
        repeat (2) cyc();
        chk("stall_hold_taps", 32'(taps), 32'b101);
        chk("stall_hold_y", 32'(y), 32'd1);
        out_ready = 1'b1;
        for (int t = 0; t < 30 && (idx < 5 || sb.size() > 0); t++) begin
            if (idx < 5) offer(idx);
            else         in_valid = 1'b0;
            cyc();
            if (last_acc) idx++;
        end
        in_valid = 1'b0;
        chk("release_accepted", 32'(idx), 32'd5);
        chk("release_drained", 32'(sb.size()), 32'd0);
        chk("release_count", 32'(count), 32'd16);

        // Flush with two in flight, coinciding with an offered input
        offer(0);
        cyc();
        offer(1);
        cyc();
        offer(2);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        repeat (4) begin
            cyc();
            chk("flush_out_valid", 32'(out_valid), 32'd0);
        end
        chk("flush_count", 32'(count), 32'd16);

        // Reset mid-stream, between clock edges
        offer(0);
        cyc();
        offer(1);
        cyc();
        offer(2);
        cyc();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_taps", 32'(taps), 32'd0);
        sb.delete();
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (4) begin
            cyc();
            chk("after_rst_valid", 32'(out_valid), 32'd0);
        end
        chk("after_rst_count", 32'(count), 32'd0);

        // Count wrap: 65535 completions, then one more
        for (int i = 0; i < 65535; i++) begin
            offer(i % 12);
            cyc();
        end
        in_valid = 1'b0;
        for (int t = 0; t < 10 && sb.size() > 0; t++) cyc();
        chk("preload_drained", 32'(sb.size()), 32'd0);
        chk("preload_count", 32'(count), 32'h0000_FFFF);
        offer(8);
        cyc();
        in_valid = 1'b0;
        for (int t = 0; t < 10 && sb.size() > 0; t++) cyc();
        chk("wrap_drained", 32'(sb.size()), 32'd0);
        chk("wrap_count", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nor_chain_pipe.md
NOR_CHAIN_PIPE -- requirements
Module: nor_chain_pipe

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning):
- STAGES, 3, number of cascaded gate stages, legal range 1..16.
- WIDTH, 1, number of independent bit lanes per stage, legal range 1..32.
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clk, input, 1, the single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- flush, input, 1, synchronous pipeline clear.
- in_valid, input, 1, input transaction present.
- in_ready, output, 1, input transaction accepted this cycle when high together with in_valid.
- a, input, WIDTH, first chain operand.
- side, input, STAGES*WIDTH, per-stage side operands; slice k is bits [k*WIDTH +: WIDTH].
- inv_en, input, 1, gate mode for this transaction: 1 = NOR, 0 = OR.
- out_valid, output, 1, output transaction present.
- out_ready, input, 1, downstream accepts the output transaction.
- y, output, WIDTH, final stage result.
- taps, output, STAGES*WIDTH, all stage results; slice k is the result of stage k.
- count, output, 16, number of completed output transactions.
REQ-003 One clock; reset is asynchronous and active-low.

Function
REQ-004 Stage function, applied bitwise per lane:
- r0 = G(a | side[0]).
- rk = G(r(k-1) | side[k]) for k >= 1.
- G is inversion when inv_en = 1 and identity when inv_en = 0.
REQ-005 With STAGES=3 and inv_en=1, the block SHALL produce e/f/g = ~(a|b), ~(e|c), ~(f|d), with b, c, d = side slices 0, 1, 2.
REQ-006 The pipeline SHALL have exactly STAGES register stages; stage k computes rk.
REQ-007 a, all side slices and inv_en SHALL be captured on acceptance and carried with the transaction. Later changes to the inputs SHALL NOT affect an accepted transaction.
REQ-008 The latency from acceptance to out_valid SHALL be STAGES cycles when out_ready is held high.
REQ-009 Each stage SHALL hold a valid bit v[k]. Stage k SHALL be ready when v[k]=0 or stage k+1 is ready. The ready of stage STAGES (the output side) is out_ready.
REQ-010 in_ready SHALL equal the ready of stage 0, combinationally.
REQ-011 Throughput SHALL be one transaction per cycle with no bubbles while out_ready = 1.
REQ-012 A stalled stage SHALL hold its data and valid bit unchanged.
REQ-013 Downstream bubbles SHALL be collapsed: a stage with v=0 accepts from upstream even when out_ready = 0.
REQ-014 Transactions SHALL leave in acceptance order; none is dropped or duplicated.
REQ-015 out_valid, y and taps SHALL come from the last stage register only. y SHALL equal the slice of taps for stage STAGES-1.
REQ-016 y and taps SHALL remain stable while out_valid=1 and out_ready=0.
REQ-017 count SHALL increment by 1 on each cycle with out_valid & out_ready, and SHALL wrap from 0xFFFF to 0x0000.
REQ-018 flush=1 SHALL clear all v[k] at the next edge and force in_ready=0 that cycle. The output handshake still counts that cycle if out_valid & out_ready, and count is not cleared.
REQ-019 When flush and acceptance would coincide, flush SHALL win and the input SHALL NOT be accepted.
REQ-020 With STAGES=1 the block SHALL be a single registered stage with latency 1.

Reset
REQ-021 While rst_n=0, regardless of clk:
- all v[k], out_valid and count SHALL be 0.
- y and taps SHALL be 0.
- in_ready SHALL be 1 one cycle after rst_n deasserts.
REQ-022 Assertion of rst_n mid-transaction SHALL discard all in-flight data, and no output handshake SHALL occur until new input is accepted.

Verification
REQ-023 STAGES=3, WIDTH=1, inv_en=1, a=0, side=3'b000, out_ready=1 -> after 3 cycles out_valid=1, taps=3'b101, y=1, count=1.
REQ-024 Same configuration, a=1, side=0 -> taps=3'b010, y=0. Then inv_en=0, a=1 -> taps=3'b111, y=1.
REQ-025 Stream 8 back-to-back transactions with out_ready=1 -> 8 outputs on 8 consecutive cycles, in order, count=8.
REQ-026 out_ready=0 with 5 transactions offered -> exactly 3 accepted and in_ready=0 after that. Release out_ready -> the held output does not change until it is taken, and all 5 complete in order.
REQ-027 With 2 transactions in flight, pulse flush -> out_valid stays 0 and count is unchanged. Assert rst_n=0 mid-stream -> out_valid=0 and count=0 immediately, without waiting for a clock edge.
REQ-028 Preload count to 0xFFFF by running 65535 transactions, then complete one more -> count=0x0000.
